exc_mem_commit: RTL

EXC_MEM_COMMIT -- requirements
Module: exc_mem_commit

---
 rtl/exc_mem_commit_pkg.sv | 30 +++
 rtl/prio_pick.sv | 22 ++
 rtl/exc_mem_commit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/exc_mem_commit_pkg.sv
// Shared types for the commit stage: FSM states, exception codes and the
// per-lane memory request record.
package exc_mem_commit_pkg;

    // Widest address/data path a lane record can carry; DATA_W must not exceed it.
    localparam int MAX_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } commit_state_t;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_NONE = 5'd0;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] addr;
        logic [MAX_DATA_W-1:0] wd;
        logic [1:0]            size;
        logic [3:0]            wstrb;
        logic                  wt;
    } mem_req_t;

    // An interrupt attached to a lane replaces whatever that lane reported.
    function automatic logic [4:0] kill_code(input logic int_hit, input logic [4:0] lane_code);
        return int_hit ? EXC_INT : lane_code;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Highest-index set bit of vec; found is low when vec is all zero.
module prio_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exc_mem_commit.sv
// Commit stage: picks the kill point of a commit group, masks retirement and
// issues the surviving memory ops oldest-first. Interrupt injection: EXC_COMMIT_INT_EN.
//
// state | meaning
// IDLE  | waiting for a group; groups without memory work finish here
// ISSUE | one request per cycle for the oldest pending lane
// DONE  | every request accepted; one-cycle grp_done pulse
module exc_mem_commit
    import exc_mem_commit_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      grp_valid,
    input  logic [LANES-1:0]          lane_valid,
    input  logic [LANES-1:0]          lane_exc,
    input  logic [LANES-1:0]          lane_eret,
    input  logic [LANES-1:0]          lane_mem,
    input  logic [LANES-1:0]          lane_wt,
    input  logic [LANES*5-1:0]        lane_exccode,
    input  logic [LANES*DATA_W-1:0]   lane_addr,
    input  logic [LANES*DATA_W-1:0]   lane_wd,
    input  logic [LANES*2-1:0]        lane_size,
    input  logic [LANES*4-1:0]        lane_wstrb,
    input  logic [5:0]                ext_int,
    input  logic                      int_enable,
    input  logic [5:0]                int_mask,
    output logic                      dmem_req,
    output logic                      dmem_wt,
    output logic [DATA_W-1:0]         dmem_addr,
    output logic [DATA_W-1:0]         dmem_wd,
    output logic [1:0]                dmem_size,
    output logic [3:0]                dmem_wstrb,
    input  logic                      dmem_addr_ok,
    output logic [LANES-1:0]          commit_mask,
    output logic                      exception_valid,
    output logic [$clog2(LANES)-1:0]  exc_lane,
    output logic [4:0]                exc_code,
    output logic                      grp_done
);

    localparam int LW = $clog2(LANES);

    commit_state_t    state;
    logic [LANES-1:0] pend;
    logic [LANES-1:0] pend_clr;
    logic [LANES-1:0] kill_vec;
    logic [LANES-1:0] issue_set;
    logic [LANES-1:0] commit_c;
    logic [LW-1:0]    kill_idx;
    logic [LW-1:0]    issue_idx;
    logic             kill_found;
    logic             issue_found;
    logic             kill_exc;
    logic             int_pend;
    logic             go_issue;
    logic             sel_unused;
    mem_req_t         sel;

`ifdef EXC_COMMIT_INT_EN
    assign int_pend = int_enable & |(ext_int & int_mask);
`else
    logic int_unused;
    assign int_unused = ^{ext_int, int_enable, int_mask};
    assign int_pend   = 1'b0;
`endif

    // A pending interrupt makes every valid lane a candidate, so the oldest valid lane wins.
    assign kill_vec = (lane_valid & (lane_exc | lane_eret)) | (int_pend ? lane_valid : '0);

    prio_pick #(.N(LANES)) u_kill (
        .vec   (kill_vec),
        .idx   (kill_idx),
        .found (kill_found)
    );

    assign kill_exc = kill_found & (int_pend | lane_exc[kill_idx]);

    always_comb begin
        commit_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!kill_found || i > int'(kill_idx)) begin
                commit_c[i] = lane_valid[i];
            end else if (i == int'(kill_idx) && !kill_exc) begin
                commit_c[i] = lane_valid[i];
            end
        end
        if (!grp_valid || !reset) begin
            commit_c = '0;
        end
    end

    assign commit_mask     = commit_c;
    assign exception_valid = reset & grp_valid & kill_exc;
    assign exc_lane        = exception_valid ? kill_idx : '0;
    assign exc_code        = exception_valid ?
                             kill_code(int_pend, lane_exccode[int'(kill_idx)*5 +: 5]) : EXC_NONE;

    assign issue_set = lane_valid & lane_mem & commit_c;
    assign go_issue  = grp_valid & ~flush & (|issue_set);

    prio_pick #(.N(LANES)) u_issue (
        .vec   (pend),
        .idx   (issue_idx),
        .found (issue_found)
    );

    always_comb begin
        sel       = '0;
        sel.addr  = MAX_DATA_W'(lane_addr[int'(issue_idx)*DATA_W +: DATA_W]);
        sel.wd    = MAX_DATA_W'(lane_wd[int'(issue_idx)*DATA_W +: DATA_W]);
        sel.size  = lane_size[int'(issue_idx)*2 +: 2];
        sel.wstrb = lane_wstrb[int'(issue_idx)*4 +: 4];
        sel.wt    = lane_wt[issue_idx];
    end

    assign sel_unused = ^{sel.addr, sel.wd};

    assign dmem_req   = (state == ST_ISSUE) & ~flush & issue_found;
    assign dmem_addr  = dmem_req ? sel.addr[DATA_W-1:0] : '0;
    assign dmem_wd    = dmem_req ? sel.wd[DATA_W-1:0]   : '0;
    assign dmem_size  = dmem_req ? sel.size  : '0;
    assign dmem_wstrb = dmem_req ? sel.wstrb : '0;
    assign dmem_wt    = dmem_req & sel.wt;

    assign pend_clr = pend & ~(LANES'(1) << issue_idx);

    always_comb begin
        case (state)
            ST_IDLE: grp_done = grp_valid & ~go_issue;
            ST_DONE: grp_done = 1'b1;
            default: grp_done = 1'b0;
        endcase
        if (!reset) begin
            grp_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            pend  <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            pend  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go_issue) begin
                        pend  <= issue_set;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (dmem_addr_ok && issue_found) begin
                        pend <= pend_clr;
                        if (pend_clr == '0) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    pend  <= '0;
                end
            endcase
        end
    end

endmodule
